// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush scheduler: FSM states, mul/div
// counter width and the packed per-stage enable/flush bundle with its presets.
package pipe_ctrl_pkg;

  localparam int MD_CNT_W = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU_HOLD = 2'd1,
    MD_WAIT = 2'd2
  } pipe_state_t;

  // Field order fixes the bit layout of the presets below (pc_we is the MSB).
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic ex_mem_flush;
    logic mem_wb_we;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_FROZEN = 8'b0000_0000;
  localparam stage_ctrl_t CTRL_RUN    = 8'b1101_0101;
  localparam stage_ctrl_t CTRL_MD     = 8'b0000_0111;
  localparam stage_ctrl_t CTRL_BR     = 8'b1111_1101;
  localparam stage_ctrl_t CTRL_LU     = 8'b0001_1101;

  function automatic logic flush_any(input stage_ctrl_t c);
    return c.if_id_flush | c.id_ex_flush | c.ex_mem_flush;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Stall-cycle and flush-event performance counters; both wrap and clear on rst.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_evt,
  input  logic             flush_evt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Event counters, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_evt) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (flush_evt) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cnt_r;
  assign flush_events = flush_cnt_r;

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Stall/flush scheduler for the 5-stage pipeline (mem wait > mul/div > branch > load-use).
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif

module pipeline_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               im_stall,
  input  logic               dm_stall,
  input  logic               ID_EX_MemRead,
  input  logic [`RegAddrBus] ID_EX_Rt,
  input  logic [4:0]         IF_ID_Rs,
  input  logic [4:0]         IF_ID_Rt,
  input  logic               branch_taken,
  input  logic               muldiv_req,
  output logic               pc_we,
  output logic               if_id_we,
  output logic               if_id_flush,
  output logic               id_ex_we,
  output logic               id_ex_flush,
  output logic               ex_mem_we,
  output logic               ex_mem_flush,
  output logic               mem_wb_we,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_events
);

  // Counter is loaded on the first stall cycle, so it spans MULDIV_LAT-2 more.
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MULDIV_LAT - 2);

  pipe_state_t          state_r, state_s;
  logic [MD_CNT_W-1:0]  md_cnt_r, md_cnt_s;
  logic                 br_pend_r, br_pend_s;
  logic                 mem_stall_s;
  logic                 hazard_s;
  logic                 br_eff_s;
  logic                 md_stall_s;
  stage_ctrl_t          ctrl_s;

  assign mem_stall_s = im_stall | dm_stall;
  assign br_eff_s    = branch_taken | br_pend_r;
  assign hazard_s    = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                       ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));
  assign md_stall_s  = ((state_r != MD_WAIT) && muldiv_req) ||
                       ((state_r == MD_WAIT) && (md_cnt_r != MD_CNT_W'(0)));

  // Priority arbitration: stage controls plus next FSM/counter/pending-branch.
  always_comb begin
    state_s   = state_r;
    md_cnt_s  = md_cnt_r;
    br_pend_s = br_pend_r;
    ctrl_s    = CTRL_RUN;
    if (rst) begin
      ctrl_s    = CTRL_FROZEN;
      state_s   = RUN;
      md_cnt_s  = MD_CNT_W'(0);
      br_pend_s = 1'b0;
    end else if (mem_stall_s) begin
      ctrl_s    = CTRL_FROZEN;
      br_pend_s = br_pend_r | branch_taken;
    end else if (md_stall_s) begin
      ctrl_s  = CTRL_MD;
      state_s = MD_WAIT;
      if (state_r == MD_WAIT) begin
        md_cnt_s = md_cnt_r - MD_CNT_W'(1);
      end else begin
        md_cnt_s = MD_LOAD;
      end
    end else if (br_eff_s) begin
      ctrl_s    = CTRL_BR;
      br_pend_s = 1'b0;
      state_s   = RUN;
    end else if ((state_r == RUN) && hazard_s) begin
      ctrl_s  = CTRL_LU;
      state_s = LU_HOLD;
    end else begin
      ctrl_s  = CTRL_RUN;
      state_s = RUN;
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RUN;
      md_cnt_r  <= MD_CNT_W'(0);
      br_pend_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      md_cnt_r  <= md_cnt_s;
      br_pend_r <= br_pend_s;
    end
  end

  assign pc_we        = ctrl_s.pc_we;
  assign if_id_we     = ctrl_s.if_id_we;
  assign if_id_flush  = ctrl_s.if_id_flush;
  assign id_ex_we     = ctrl_s.id_ex_we;
  assign id_ex_flush  = ctrl_s.id_ex_flush;
  assign ex_mem_we    = ctrl_s.ex_mem_we;
  assign ex_mem_flush = ctrl_s.ex_mem_flush;
  assign mem_wb_we    = ctrl_s.mem_wb_we;

`ifdef PIPE_PERF_CNT_EN
  logic stall_evt_s;
  logic flush_evt_s;

  assign stall_evt_s = ~ctrl_s.pc_we & ~rst;
  assign flush_evt_s = flush_any(ctrl_s);

  pipe_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_evt    (stall_evt_s),
    .flush_evt    (flush_evt_s),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );
`else
  assign stall_cycles = {CNT_W{1'b0}};
  assign flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Self-checking bench for pipeline_ctrl_unit: directed scenarios plus random
// traffic against a behavioural model of the scheduling rules.
module tb_pipeline_ctrl_unit;

  localparam int LAT   = 4;
  localparam int CNT_W = 32;

  localparam logic [7:0] E_NORM = 8'b1101_0101;
  localparam logic [7:0] E_FRZ  = 8'b0000_0000;
  localparam logic [7:0] E_MD   = 8'b0000_0111;
  localparam logic [7:0] E_BR   = 8'b1111_1101;
  localparam logic [7:0] E_LU   = 8'b0001_1101;

  logic clk = 1'b0;
  logic rst, im_stall, dm_stall, ID_EX_MemRead, branch_taken, muldiv_req;
  logic [4:0] ID_EX_Rt, IF_ID_Rs, IF_ID_Rt;
  logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush, mem_wb_we;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [7:0] outs;

  int total = 0;
  int bad   = 0;

  // Model state: what the pipeline has "seen", not how the RTL encodes it.
  bit          md_active = 1'b0;
  int          md_left   = 0;
  bit          lu_done   = 1'b0;
  bit          pend      = 1'b0;
  logic [31:0] m_stall   = 32'd0;
  logic [31:0] m_flush   = 32'd0;

  always #5 clk = ~clk;

  pipeline_ctrl_unit #(.MULDIV_LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .im_stall(im_stall), .dm_stall(dm_stall),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt), .IF_ID_Rs(IF_ID_Rs),
    .IF_ID_Rt(IF_ID_Rt), .branch_taken(branch_taken), .muldiv_req(muldiv_req),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_we(id_ex_we),
    .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we), .ex_mem_flush(ex_mem_flush),
    .mem_wb_we(mem_wb_we), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  assign outs = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush, mem_wb_we};

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      assert (!(muldiv_req && branch_taken));
    end
  end

  function automatic bit hazard();
    return ID_EX_MemRead && (ID_EX_Rt != 5'd0) && ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));
  endfunction

  function automatic bit md_stalling();
    return md_active ? (md_left > 0) : muldiv_req;
  endfunction

  function automatic logic [7:0] model_exp();
    if (rst) return E_FRZ;
    if (im_stall || dm_stall) return E_FRZ;
    if (md_stalling()) return E_MD;
    if (branch_taken || pend) return E_BR;
    if (!md_active && !lu_done && hazard()) return E_LU;
    return E_NORM;
  endfunction

  function automatic logic [31:0] exp_stall_cnt();
`ifdef PIPE_PERF_CNT_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_flush_cnt();
`ifdef PIPE_PERF_CNT_EN
    return m_flush;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_update();
    logic [7:0] e;
    e = model_exp();
    if (rst) begin
      md_active = 1'b0; md_left = 0; lu_done = 1'b0; pend = 1'b0;
      m_stall = 32'd0; m_flush = 32'd0;
    end else begin
      if (!e[7]) m_stall = m_stall + 32'd1;
      if (e[5] || e[3] || e[1]) m_flush = m_flush + 32'd1;
      if (im_stall || dm_stall) begin
        pend = pend | branch_taken;
      end else if (md_stalling()) begin
        if (!md_active) begin
          md_active = 1'b1;
          md_left   = LAT - 1;
        end
        md_left = md_left - 1;
        lu_done = 1'b0;
      end else if (branch_taken || pend) begin
        pend = 1'b0; md_active = 1'b0; lu_done = 1'b0;
      end else if (!md_active && !lu_done && hazard()) begin
        lu_done = 1'b1;
      end else begin
        md_active = 1'b0; lu_done = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic im, input logic dm, input logic mr,
                       input logic [4:0] rt_ex, input logic [4:0] rs_id, input logic [4:0] rt_id,
                       input logic br, input logic md);
    rst = r; im_stall = im; dm_stall = dm; ID_EX_MemRead = mr;
    ID_EX_Rt = rt_ex; IF_ID_Rs = rs_id; IF_ID_Rt = rt_id;
    branch_taken = br; muldiv_req = md;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (outs !== E_FRZ) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs, E_FRZ); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (outs !== E_NORM) begin bad++; $display("FAIL reset_idle got=%b exp=%b", outs, E_NORM); end
    total++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_events);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [7:0] exp_seq [3];
    exp_seq = '{E_LU, E_NORM, E_NORM};
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd7, 1'b0, 1'b0);
      else       drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (outs !== exp_seq[i]) begin bad++; $display("FAIL load_use c%0d got=%b exp=%b", i, outs, exp_seq[i]); end
      tick();
    end
  endtask

  task automatic test_muldiv();
    logic [7:0] exp_seq [5];
    exp_seq = '{E_MD, E_MD, E_MD, E_NORM, E_NORM};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (i < 4));
      @(negedge clk);
      total++;
      if (outs !== exp_seq[i]) begin bad++; $display("FAIL muldiv c%0d got=%b exp=%b", i, outs, exp_seq[i]); end
      tick();
    end
  endtask

  task automatic test_branch_vs_lu();
    logic [7:0] exp_seq [2];
    exp_seq = '{E_BR, E_NORM};
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, (i == 0), 5'd5, 5'd5, 5'd0, (i == 0), 1'b0);
      @(negedge clk);
      total++;
      if (outs !== exp_seq[i]) begin bad++; $display("FAIL br_vs_lu c%0d got=%b exp=%b", i, outs, exp_seq[i]); end
      tick();
    end
  endtask

  task automatic test_branch_mem_stall();
    logic [7:0] exp_seq [5];
    exp_seq = '{E_FRZ, E_FRZ, E_FRZ, E_BR, E_NORM};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, (i < 3), 1'b0, 5'd0, 5'd0, 5'd0, (i == 0), 1'b0);
      @(negedge clk);
      total++;
      if (outs !== exp_seq[i]) begin bad++; $display("FAIL br_dm_stall c%0d got=%b exp=%b", i, outs, exp_seq[i]); end
      tick();
    end
  endtask

  task automatic test_md_mem_stall();
    logic [7:0] exp_seq [7];
    logic [31:0] s0;
    exp_seq = '{E_MD, E_MD, E_FRZ, E_FRZ, E_MD, E_NORM, E_NORM};
    s0 = m_stall;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, (i == 2 || i == 3), 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (i < 6));
      @(negedge clk);
      total++;
      if (outs !== exp_seq[i]) begin bad++; $display("FAIL md_im_stall c%0d got=%b exp=%b", i, outs, exp_seq[i]); end
      tick();
    end
    total++;
    if (m_stall - s0 !== 32'(LAT - 1 + 2)) begin
      bad++; $display("FAIL md_stall_total got=%0d exp=%0d", m_stall - s0, LAT + 1);
    end
  endtask

  task automatic test_reset_mid_md();
    logic [7:0] exp_seq [5];
    exp_seq = '{E_MD, E_MD, E_FRZ, E_NORM, E_MD};
    for (int i = 0; i < 5; i++) begin
      drive((i == 2), 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (i != 3));
      @(negedge clk);
      total++;
      if (outs !== exp_seq[i]) begin bad++; $display("FAIL reset_md c%0d got=%b exp=%b", i, outs, exp_seq[i]); end
      if (i == 3) begin
        total++;
        if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
          bad++; $display("FAIL reset_md_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_events);
        end
      end
      tick();
    end
    for (int i = 0; i < LAT; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_random();
    logic br;
    for (int i = 0; i < 800; i++) begin
      br = ($urandom_range(0, 5) == 0);
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            br, (!br && $urandom_range(0, 7) == 0));
      @(negedge clk);
      total++;
      if (outs !== model_exp()) begin
        bad++; $display("FAIL random c%0d got=%b exp=%b", i, outs, model_exp());
      end
      total++;
      if (stall_cycles !== exp_stall_cnt() || flush_events !== exp_flush_cnt()) begin
        bad++; $display("FAIL random_cnt c%0d got=%0d/%0d exp=%0d/%0d", i, stall_cycles, flush_events,
                        exp_stall_cnt(), exp_flush_cnt());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_muldiv();
    test_branch_vs_lu();
    test_branch_mem_stall();
    test_md_mem_stall();
    test_reset_mid_md();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl_unit.md
Name: pipeline_ctrl_unit

Overview:
- Central stall/flush scheduler for the 5-stage CPU pipeline.
- Arbitrates four sources into per-stage register enables, flushes and the PC write enable:
  - memory wait (IM/DM)
  - multi-cycle mul/div occupancy of EX
  - taken branch redirect from EX
  - load-use hazard between ID and EX
- Owns the load-use detection and the mul/div occupancy counter; the pipeline registers obey its outputs only.

Parameters:
- MULDIV_LAT, 4: cycles a mul/div instruction occupies EX, including its first cycle; legal range 2..15.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- im_stall  in  1  instruction memory not ready
- dm_stall  in  1  data memory not ready
- ID_EX_MemRead  in  1  EX-stage instruction is a load
- ID_EX_Rt  in  5 (`RegAddrBus)  load destination register
- IF_ID_Rs  in  5  ID source register 1
- IF_ID_Rt  in  5  ID source register 2
- branch_taken  in  1  EX resolved a taken branch or jump
- muldiv_req  in  1  level; mul/div instruction currently in EX
- pc_we  out  1  PC update enable
- if_id_we  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID load bubble
- id_ex_we  out  1  ID/EX register enable
- id_ex_flush  out  1  ID/EX load bubble
- ex_mem_we  out  1  EX/MEM register enable
- ex_mem_flush  out  1  EX/MEM load bubble
- mem_wb_we  out  1  MEM/WB register enable
- stall_cycles  out  CNT_W  performance counter (optional feature)
- flush_events  out  CNT_W  performance counter (optional feature)

Behaviour:
- State: FSM {RUN, LU_HOLD, MD_WAIT}, 4-bit md_cnt, br_pend flag.
- Reset: while rst=1, all *_we=0 and all *_flush=0. Next cycle: state=RUN, md_cnt=0, br_pend=0.
- Default (RUN, no event): all *_we=1, all *_flush=0.
- Priority, highest first: mem stall > mul/div > branch > load-use.
- Mem stall (im_stall|dm_stall):
  - All *_we=0, all flushes=0.
  - FSM and md_cnt hold.
  - If branch_taken=1, set br_pend.
- Effective branch: br_eff = branch_taken | br_pend.
- Mul/div, not mem-stalled:
  - RUN & muldiv_req: stall cycle. Load md_cnt=MULDIV_LAT-2, go to MD_WAIT.
  - MD_WAIT & md_cnt!=0: stall cycle, md_cnt decrements.
  - MD_WAIT & md_cnt==0: normal advance, go to RUN.
  - Stall cycle means pc_we=if_id_we=id_ex_we=0, ex_mem_we=1, ex_mem_flush=1, mem_wb_we=1.
  - Result: exactly MULDIV_LAT-1 stall cycles per instruction.
- Branch (br_eff, not mem-stalled, not a mul/div stall cycle):
  - pc_we=1, if_id_flush=1, id_ex_flush=1, other we=1.
  - br_pend cleared.
  - Load-use suppressed in the same cycle.
- Load-use, in RUN only:
  - Hazard = ID_EX_MemRead & ID_EX_Rt!=0 & (ID_EX_Rt==IF_ID_Rs | ID_EX_Rt==IF_ID_Rt).
  - Response: pc_we=0, if_id_we=0, id_ex_we=1, id_ex_flush=1. Next state LU_HOLD.
- LU_HOLD:
  - Hazard compare ignored, so a load-use produces exactly one bubble.
  - Otherwise behaves as RUN. Returns to RUN after one non-mem-stalled cycle.
- Mem stall arriving in a load-use cycle: the load-use is not taken. FSM stays in RUN and re-evaluates next cycle.
- muldiv_req & branch_taken together are illegal; the bench asserts this never occurs.
- Reset asserted mid-MD_WAIT or with br_pend=1: both are discarded.
- All outputs combinational from state and inputs; no added latency.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every cycle with pc_we=0 and rst=0.
  - flush_events increments on every cycle with if_id_flush|id_ex_flush|ex_mem_flush.
  - Both wrap at 2^CNT_W and clear on rst.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - typedef enum pipe_state_t {RUN, LU_HOLD, MD_WAIT}
  - MD_CNT_W=4
  - stage-control struct typedef (we/flush bundle)
- `RegAddrBus comes from the existing define header.
- Sub-module pipe_perf_cnt (two counters), instantiated only under PIPE_PERF_CNT_EN.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5 held for 2 cycles -> cycle 1: pc_we=0, if_id_we=0, id_ex_flush=1; cycle 2: all we=1, no flush. With ID_EX_Rt=0 -> no stall.
- Mul/div, MULDIV_LAT=4: muldiv_req=1 for 4 cycles -> 3 cycles with pc_we=0, ex_mem_flush=1, then 1 advance cycle with all we=1.
- Branch vs load-use: branch_taken=1 with a simultaneous load-use match -> pc_we=1, if_id_flush=1, id_ex_flush=1, no stall.
- Branch under dm_stall: branch_taken=1 for 1 cycle during 3 cycles of dm_stall=1, then 0 -> 3 frozen cycles (all we=0), then 1 flush cycle.
- Mem stall in MD_WAIT: im_stall=1 for 2 cycles while md_cnt=1 -> md_cnt holds at 1; total mul/div stall cycles = MULDIV_LAT-1 plus 2.
- Reset at 2nd MD_WAIT cycle: rst=1 for 1 cycle -> outputs all 0 that cycle, then RUN. With PIPE_PERF_CNT_EN defined, counters read 0.
